// File: rtl/sr_drive_ctrl_pkg.sv
// sr_drive_ctrl_pkg: shared FSM state encoding and default parameter values for the SR drive controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sr_drive_ctrl_pkg;

  localparam int DB_CYCLES_DEF    = 4;
  localparam int PULSE_CYCLES_DEF = 2;
  localparam int CNT_W_DEF        = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    DRIVE_S = 2'b01,
    DRIVE_R = 2'b10,
    GAP     = 2'b11
  } state_e;

endpackage

// File: rtl/sr_debounce.sv
// sr_debounce: 2-FF synchroniser, level debouncer and rising-edge pulse for one raw request line.
// Latency: rise_o pulses 2+DB_CYCLES edges after the first edge sampling a held-high req_i.
// Backpressure: none; rise_o is a single-cycle pulse the consumer must capture.
module sr_debounce
  import sr_drive_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic req_i,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             rise_q;
  logic [CNT_W-1:0] cnt_q;

  // Synchronise, then move the level only after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= req_i;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      if (sync2_q != level_q) begin
        if (cnt_q == DB_LAST) begin
          level_q <= sync2_q;
          rise_q  <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_ONE;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/sr_drive_ctrl.sv
// sr_drive_ctrl: turns raw set/clear push-button requests into clean, mutually exclusive s/r latch pulses.
// Latency: s/r rise 2+DB_CYCLES+1 edges after the first edge sampling a held request; pulse lasts PULSE_CYCLES.
// Backpressure: one pending slot per direction, repeats merge; build macro SR_MON_EN adds the q/q_bar monitor.
module sr_drive_ctrl
  import sr_drive_ctrl_pkg::*;
#(
  parameter int DB_CYCLES    = DB_CYCLES_DEF,
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic set_req,
  input  logic clr_req,
`ifdef SR_MON_EN
  input  logic q,
  input  logic q_bar,
  output logic mon_err,
`endif
  output logic s,
  output logic r,
  output logic busy,
  output logic exp_q
);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_s_q, pend_s_d;
  logic             pend_r_q, pend_r_d;
  logic             s_q, r_q, busy_q;
  logic             rise_s, rise_r;

  sr_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_set (
    .clk    (clk),
    .reset  (reset),
    .req_i  (set_req),
    .rise_o (rise_s)
  );

  sr_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_clr (
    .clk    (clk),
    .reset  (reset),
    .req_i  (clr_req),
    .rise_o (rise_r)
  );

  // Fold fresh edges into the pending flags, then let IDLE serve clear ahead of set.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_s_d = pend_s_q | rise_s;
    pend_r_d = pend_r_q | rise_r;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pend_r_d) begin
          state_d  = DRIVE_R;
          pend_r_d = 1'b0;
        end else if (pend_s_d) begin
          state_d  = DRIVE_S;
          pend_s_d = 1'b0;
        end
      end
      DRIVE_S, DRIVE_R: begin
        if (cnt_q == PULSE_LAST) begin
          state_d = GAP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Drives are registered from the next state so they switch on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      pend_s_q <= 1'b0;
      pend_r_q <= 1'b0;
      s_q      <= 1'b0;
      r_q      <= 1'b0;
      busy_q   <= 1'b0;
      exp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pend_s_q <= pend_s_d;
      pend_r_q <= pend_r_d;
      s_q      <= (state_d == DRIVE_S);
      r_q      <= (state_d == DRIVE_R);
      busy_q   <= (state_d != IDLE);
      if (state_d == DRIVE_S && state_q != DRIVE_S) begin
        exp_q <= 1'b1;
      end else if (state_d == DRIVE_R && state_q != DRIVE_R) begin
        exp_q <= 1'b0;
      end
    end
  end

`ifdef SR_MON_EN
  // The latch has settled by GAP; any disagreement with the commanded state sticks until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mon_err <= 1'b0;
    end else if (state_q == GAP && (q != exp_q || q_bar != ~exp_q)) begin
      mon_err <= 1'b1;
    end
  end
`endif

  assign s    = s_q;
  assign r    = r_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// tb_sr_drive_ctrl: directed scenarios plus randomized request traffic against a timeline reference model.
// Latency: checks every cycle, 1 time unit after the rising edge.
// Backpressure: n/a.
module tb_sr_drive_ctrl;

  localparam int DB = 4;
  localparam int P  = 2;

  logic clk = 1'b0;
  logic reset;
  logic set_req;
  logic clr_req;
  logic s, r, busy, exp_q;
`ifdef SR_MON_EN
  logic q, q_bar, mon_err;
  bit   q_bad;
  bit   mon_m;
`endif

  int n_cmp;
  int n_err;

  // Reference model: edge index, raw sample history, debounced levels, pending flags, command timeline.
  int n;
  bit hs[$];
  bit hc[$];
  bit lvl_s, lvl_c;
  bit pend_s, pend_r;
  int cmd_start;
  int free_at;
  bit cmd_is_s;
  bit exp_m;
  int lat;
  int r_first, s_first;

  always #5 clk = ~clk;

  sr_drive_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .set_req (set_req),
    .clr_req (clr_req),
`ifdef SR_MON_EN
    .q       (q),
    .q_bar   (q_bar),
    .mon_err (mon_err),
`endif
    .s       (s),
    .r       (r),
    .busy    (busy),
    .exp_q   (exp_q)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (edge %0d)", tag, got, want, n);
    end
  endtask

  // A level flips once the last DB synchronised samples (raw delayed by two edges) all disagree with it.
  function automatic bit settles(input bit h[$], input bit lvl);
    if (h.size() < DB + 2) return 1'b0;
    for (int i = h.size() - DB - 2; i <= h.size() - 3; i++) begin
      if (h[i] == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_edge();
    n++;
    if (reset) begin
      hs.delete();
      hc.delete();
      lvl_s     = 1'b0;
      lvl_c     = 1'b0;
      pend_s    = 1'b0;
      pend_r    = 1'b0;
      cmd_start = -100;
      free_at   = 0;
      exp_m     = 1'b0;
`ifdef SR_MON_EN
      mon_m     = 1'b0;
`endif
      return;
    end
`ifdef SR_MON_EN
    if (n - 1 == cmd_start + P && (q !== exp_m || q_bar !== !exp_m)) mon_m = 1'b1;
`endif
    // A command can start once the previous one plus its gap and idle cycle are over.
    if (n >= free_at && (pend_r || pend_s)) begin
      cmd_is_s = !pend_r;
      if (pend_r) pend_r = 1'b0;
      else        pend_s = 1'b0;
      cmd_start = n;
      free_at   = n + P + 2;
      exp_m     = cmd_is_s;
    end
    hs.push_back(set_req);
    hc.push_back(clr_req);
    if (hs.size() > DB + 2) void'(hs.pop_front());
    if (hc.size() > DB + 2) void'(hc.pop_front());
    if (settles(hs, lvl_s)) begin
      lvl_s = !lvl_s;
      if (lvl_s) pend_s = 1'b1;
    end
    if (settles(hc, lvl_c)) begin
      lvl_c = !lvl_c;
      if (lvl_c) pend_r = 1'b1;
    end
  endtask

  task automatic check_outputs();
    bit act;
    bit bsy;
    act = (n >= cmd_start) && (n < cmd_start + P);
    bsy = (n >= cmd_start) && (n <= cmd_start + P);
    chk("s", s, act && cmd_is_s);
    chk("r", r, act && !cmd_is_s);
    chk("busy", busy, bsy);
    chk("exp_q", exp_q, exp_m);
    chk("s_and_r", s & r, 1'b0);
`ifdef SR_MON_EN
    chk("mon_err", mon_err, mon_m);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
`ifdef SR_MON_EN
    q     = q_bad ? 1'b0 : exp_m;
    q_bar = ~q;
`endif
  endtask

  task automatic run(input int k);
    repeat (k) tick();
  endtask

  initial begin
    n_cmp = 0; n_err = 0; n = 0;
    cmd_start = -100; free_at = 0; exp_m = 1'b0;
    reset = 1'b1; set_req = 1'b1; clr_req = 1'b0;
`ifdef SR_MON_EN
    q_bad = 1'b0; q = 1'b0; q_bar = 1'b1;
`endif

    // Reset held two edges with a set request present.
    tick();
    tick();
    chk("rst_s", s, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_exp", exp_q, 1'b0);
    reset = 1'b0; set_req = 1'b0;
    run(12);

    // Clean set: first s edge counted from the first edge sampling the request.
    set_req = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      tick();
      if (s) lat = k;
    end
    chk("lat_s", lat, 7);
    run(10);
    chk("set_exp", exp_q, 1'b1);
    set_req = 1'b0;
    run(12);

    // Clear so the bounce test starts from exp_q=0.
    clr_req = 1'b1; run(12);
    clr_req = 1'b0; run(12);

    // Bounce: 1,0,1,0 glitches never settle; a 5-cycle hold does.
    set_req = 1'b1; tick();
    set_req = 1'b0; tick();
    set_req = 1'b1; tick();
    set_req = 1'b0; tick();
    run(12);
    chk("bounce_exp", exp_q, 1'b0);
    set_req = 1'b1; run(5);
    set_req = 1'b0; run(12);
    chk("hold5_exp", exp_q, 1'b1);

    // Simultaneous: clear served first, set follows after GAP and IDLE.
    set_req = 1'b1; clr_req = 1'b1;
    r_first = 0; s_first = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (r && r_first == 0) r_first = k;
      if (s && s_first == 0) s_first = k;
    end
    chk("simul_r_first", r_first, 7);
    chk("simul_s_first", s_first, 7 + P + 2);
    chk("simul_exp", exp_q, 1'b1);
    set_req = 1'b0; clr_req = 1'b0;
    run(15);

    // Reset during the second r cycle drops r, busy and the pending set.
    set_req = 1'b1; clr_req = 1'b1;
    run(8);
    chk("mid_r_on", r, 1'b1);
    reset = 1'b1; set_req = 1'b0; clr_req = 1'b0;
    tick();
    chk("mid_r_off", r, 1'b0);
    chk("mid_busy", busy, 1'b0);
    reset = 1'b0;
    run(15);
    chk("mid_no_set", exp_q, 1'b0);

`ifdef SR_MON_EN
    // Latch stuck low after a set: error raised in GAP and held until reset.
    set_req = 1'b1; q_bad = 1'b1;
    run(12);
    chk("mon_set", mon_err, 1'b1);
    set_req = 1'b0; q_bad = 1'b0;
    run(5);
    chk("mon_sticky", mon_err, 1'b1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mon_clr", mon_err, 1'b0);
`endif

    // Random request traffic with occasional resets.
    for (int seg = 0; seg < 120; seg++) begin
      reset   = ($urandom_range(0, 29) == 0);
      set_req = 1'($urandom_range(0, 1));
      clr_req = 1'($urandom_range(0, 1));
      if (reset) tick();
      else       run($urandom_range(1, 9));
      reset = 1'b0;
    end
    set_req = 1'b0; clr_req = 1'b0;
    run(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
